// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types and constants for the round-robin A2D interface
package a2d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP,
        ST_RD
    } a2d_state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_FRONT,
        SPI_SHIFT,
        SPI_BACK
    } spi_state_t;

    localparam logic [2:0] DEF_CH_LFT   = 3'd0;
    localparam logic [2:0] DEF_CH_RGHT  = 3'd4;
    localparam logic [2:0] DEF_CH_STEER = 3'd5;
    localparam logic [2:0] DEF_CH_BATT  = 3'd6;

    localparam logic [4:0] DIV_PRELOAD = 5'b10111;
    localparam int         XFER_LEN    = 16;

    // First transaction of a conversion selects the channel; its response is junk.
    function automatic logic [15:0] chan_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// rtl/spi_mnrch.sv - 16-bit SPI master, SCLK = clk/32 idling high
module spi_mnrch
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] resp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    spi_state_t  state, nxt_state;
    logic [4:0]  div;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        miso_smpl;
    logic        ss_n_q;
    logic        ld, smpl, shft;

    logic sclk_rise_nxt, sclk_fall_nxt;
    assign sclk_rise_nxt = (div == 5'b01111);
    assign sclk_fall_nxt = (div == 5'b11111);

    always_comb begin
        nxt_state = state;
        ld        = 1'b0;
        smpl      = 1'b0;
        shft      = 1'b0;
        done      = 1'b0;
        case (state)
            SPI_IDLE: begin
                if (wrt) begin
                    ld        = 1'b1;
                    nxt_state = SPI_FRONT;
                end
            end
            // The first SCLK fall only opens the frame; nothing is shifted yet.
            SPI_FRONT: begin
                if (sclk_fall_nxt)
                    nxt_state = SPI_SHIFT;
            end
            SPI_SHIFT: begin
                if (sclk_rise_nxt) begin
                    smpl = 1'b1;
                    if (bit_cnt == 5'(XFER_LEN - 1))
                        nxt_state = SPI_BACK;
                end
                if (sclk_fall_nxt)
                    shft = 1'b1;
            end
            SPI_BACK: begin
                if (sclk_fall_nxt) begin
                    shft      = 1'b1;
                    done      = 1'b1;
                    nxt_state = SPI_IDLE;
                end
            end
            default: nxt_state = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SPI_IDLE;
            div       <= DIV_PRELOAD;
            bit_cnt   <= '0;
            shift_reg <= '0;
            miso_smpl <= 1'b0;
            ss_n_q    <= 1'b1;
        end else begin
            state <= nxt_state;
            // Divider rests at the preload while idle and starts counting on wrt.
            if (done)
                div <= DIV_PRELOAD;
            else if (ld || (state != SPI_IDLE))
                div <= div + 5'd1;
            if (ld) begin
                shift_reg <= cmd;
                bit_cnt   <= '0;
                ss_n_q    <= 1'b0;
            end else if (shft) begin
                shift_reg <= {shift_reg[14:0], miso_smpl};
            end
            if (smpl) begin
                miso_smpl <= MISO;
                bit_cnt   <= bit_cnt + 5'd1;
            end
            if (done)
                ss_n_q <= 1'b1;
        end
    end

    // Valid only while done is high: includes the final shift taking place that edge.
    assign resp = {shift_reg[14:0], miso_smpl};
    assign SS_n = ss_n_q;
    assign SCLK = div[4];
    assign MOSI = shift_reg[15];

endmodule

// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - round-robin conversion of four A2D channels via spi_mnrch
module a2d_intf
    import a2d_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = DEF_CH_LFT,
    parameter logic [2:0] CH_RGHT  = DEF_CH_RGHT,
    parameter logic [2:0] CH_STEER = DEF_CH_STEER,
    parameter logic [2:0] CH_BATT  = DEF_CH_BATT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);

    a2d_state_t  state, nxt_state;
    logic [1:0]  ptr;
    logic [2:0]  sel_ch;
    logic        wrt, done;
    logic [15:0] cmd, resp;
    logic [3:0]  resp_unused;

    assign resp_unused = resp[15:12];

    always_comb begin
        case (ptr)
            2'd0:    sel_ch = CH_LFT;
            2'd1:    sel_ch = CH_RGHT;
            2'd2:    sel_ch = CH_STEER;
            default: sel_ch = CH_BATT;
        endcase
    end

    spi_mnrch u_spi (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt),
        .cmd  (cmd),
        .done (done),
        .resp (resp),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    // wrt is issued on the entering transition so the inter-transaction gap is one cycle.
    always_comb begin
        nxt_state = state;
        wrt       = 1'b0;
        cmd       = 16'h0000;
        cnv_cmplt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (nxt) begin
                    wrt       = 1'b1;
                    cmd       = chan_cmd(sel_ch);
                    nxt_state = ST_CMD;
                end
            end
            ST_CMD: begin
                if (done)
                    nxt_state = ST_GAP;
            end
            ST_GAP: begin
                wrt       = 1'b1;
                nxt_state = ST_RD;
            end
            ST_RD: begin
                if (done) begin
                    cnv_cmplt = 1'b1;
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            state <= nxt_state;
            if (cnv_cmplt) begin
                ptr <= ptr + 2'd1;
                case (ptr)
                    2'd0:    lft_ld    <= resp[11:0];
                    2'd1:    rght_ld   <= resp[11:0];
                    2'd2:    steer_pot <= resp[11:0];
                    default: batt      <= resp[11:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// tb/tb_a2d_intf.sv - randomized self-checking bench for a2d_intf with an A2D slave model
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        nxt = 1'b0;
    logic        miso = 1'b0;
    logic        SS_n, SCLK, MOSI, cnv_cmplt;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .MISO      (miso),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: channel rotation and expected result registers.
    logic [2:0]  ch_tbl [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [11:0] exp_reg [4];
    int          ptr = 0;

    // A2D slave: shifts out tx MSB first, changing on SCLK falls after the first, captures MOSI on rises.
    logic [15:0] tx_q [$];
    logic [15:0] rx_q [$];
    logic        m_ss = 1'b1, m_sclk = 1'b1;
    int          nr = 0;
    logic [15:0] tx = '0, rx = '0;

    always @(SS_n or SCLK) begin
        if (SS_n !== m_ss) begin
            if (!SS_n) begin
                tx   = (tx_q.size() > 0) ? tx_q.pop_front() : 16'h0000;
                nr   = 0;
                rx   = '0;
                miso = tx[15];
            end else if (nr == 16) begin
                rx_q.push_back(rx);
            end
        end else if ((SCLK !== m_sclk) && !SS_n) begin
            if (SCLK) begin
                rx = {rx[14:0], MOSI};
                nr++;
            end else if (nr > 0 && nr < 16) begin
                miso = tx[15 - nr];
            end
        end
        m_ss   = SS_n;
        m_sclk = SCLK;
    end

    // Bus monitor: frame timing per transaction, gap between the two transactions, idle SCLK activity.
    int n_start = 0, n_cnv = 0, idle_edges = 0;
    int low_cnt = 0, rises = 0, front_high = 0, gap_cnt = 0;
    bit seen_fall = 0, second = 0;
    bit p_ss = 1, p_sclk = 1;

    always @(negedge clk) begin
        if (rst) begin
            p_ss   = 1;
            p_sclk = 1;
            second = 0;
        end else begin
            if (cnv_cmplt)
                n_cnv++;
            if (!SS_n) begin
                if (p_ss) begin
                    n_start++;
                    if (second)
                        check("gap_cycles", gap_cnt, 1);
                    low_cnt    = 0;
                    rises      = 0;
                    front_high = 0;
                    seen_fall  = 0;
                end
                low_cnt++;
                if (SCLK && !p_sclk) rises++;
                if (!SCLK && p_sclk) seen_fall = 1;
                if (!seen_fall && SCLK) front_high++;
            end else begin
                if (!p_ss) begin
                    check("ss_low_cycles", low_cnt, 520);
                    check("sclk_rises", rises, 16);
                    check("front_high", front_high, 8);
                    second  = !second;
                    gap_cnt = 0;
                end
                gap_cnt++;
                if (p_ss && (SCLK != p_sclk))
                    idle_edges++;
            end
            p_ss   = SS_n;
            p_sclk = SCLK;
        end
    end

    task automatic check_regs();
        check("lft_ld", lft_ld, exp_reg[0]);
        check("rght_ld", rght_ld, exp_reg[1]);
        check("steer_pot", steer_pot, exp_reg[2]);
        check("batt", batt, exp_reg[3]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ss_n", SS_n, 1);
        check("rst_sclk", SCLK, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_cnv", cnv_cmplt, 0);
        for (int i = 0; i < 4; i++) exp_reg[i] = '0;
        ptr = 0;
        check_regs();
        rst = 1'b0;
    endtask

    // One conversion; extra=1 also pulses nxt in CMD, GAP, RD and the cnv_cmplt cycle.
    task automatic conv(input logic [15:0] v, input bit extra);
        int lat, s0, c0;
        tx_q.delete();
        rx_q.delete();
        tx_q.push_back(16'($urandom));
        tx_q.push_back(v);
        s0  = n_start;
        c0  = n_cnv;
        lat = 0;
        @(negedge clk);
        nxt = 1'b1;
        for (int k = 1; k <= 1300; k++) begin
            @(negedge clk);
            nxt = extra && (k == 5 || k == 521 || k == 700 || cnv_cmplt);
            if (cnv_cmplt) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        nxt = 1'b0;
        check("latency", lat, 1041);
        repeat (60) @(negedge clk);
        check("cnv_pulses", n_cnv - c0, 1);
        check("xfers", n_start - s0, 2);
        check("cmd_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("cmd_chan", rx_q[0], {2'b00, ch_tbl[ptr], 11'h000});
            check("cmd_read", rx_q[1], 16'h0000);
        end
        exp_reg[ptr] = v[11:0];
        ptr = (ptr + 1) % 4;
        check_regs();
    endtask

    initial begin
        int c0;
        #1;
        do_reset();
        repeat (2000) @(negedge clk);
        check("idle_sclk_edges", idle_edges, 0);
        check("idle_xfers", n_start, 0);

        conv(16'hF123, 1'b0);

        do_reset();
        conv({4'($urandom), 12'h0A1}, 1'b0);
        conv({4'($urandom), 12'h0B2}, 1'b0);
        conv({4'($urandom), 12'h0C3}, 1'b0);
        conv({4'($urandom), 12'h0D4}, 1'b0);
        conv(16'($urandom), 1'b0);

        conv(16'($urandom), 1'b1);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            conv(16'($urandom), (i == 2));
        end

        // Abort in the 200th cycle of RD, then confirm a clean restart on the left channel.
        do_reset();
        tx_q.delete();
        rx_q.delete();
        tx_q.push_back(16'($urandom));
        tx_q.push_back(16'h0FFF);
        c0 = n_cnv;
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        repeat (720) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_ss_n", SS_n, 1);
        check("abort_sclk", SCLK, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_cnv", n_cnv - c0, 0);
        check_regs();
        conv(16'($urandom), 1'b0);

        check("final_idle_edges", idle_edges, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
